// File: rtl/ac97_frame_receiver.sv
// ac97_frame_receiver
// Receive side of the AC'97 link. It deserialises SDATA_IN from the codec and
// recovers three things: the codec-ready flag from the tag, the register
// read-back address and data from slots 1 and 2, and the 20-bit left/right
// capture samples from slots 3 and 4. It also checks SYNC framing.
//
// Frame bit n is the SDATA_IN sample taken while the bit counter equals n.
// A sync rising edge always makes the current cycle bit 0 of a new frame.
// That holds whether the edge comes from IDLE, at the normal 255->0 wrap, or
// early in the middle of a frame. All outputs are registered.

module ac97_frame_receiver (
    input  logic        ac97_bitclk,
    input  logic        reset_n,
    input  logic        ac97_sync,
    input  logic        ac97_sdata_in,
    output logic        codec_ready,
    output logic [9:0]  slot_req,
    output logic [6:0]  status_addr,
    output logic [15:0] status_data,
    output logic        status_valid,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right,
    output logic        pcm_valid,
    output logic        frame_error
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Frame bit positions where the decoder acts on the just-completed word.
    localparam logic [7:0] BC_TAG_END   = 8'd15;
    localparam logic [7:0] BC_SLOT1_END = 8'd35;
    localparam logic [7:0] BC_SLOT2_END = 8'd55;
    localparam logic [7:0] BC_SLOT3_END = 8'd75;
    localparam logic [7:0] BC_SLOT4_END = 8'd95;
    localparam logic [7:0] BC_SYNC_LEN  = 8'd16;

    // Framing state
    logic [0:0]  state_q, state_d;
    logic [7:0]  bc_q, bc_d;
    logic        sync_q, sync_d;
    logic        err_seen_q, err_seen_d;

    // Data path: 19 stored bits plus the live input form the 20-bit word
    logic [18:0] shift_q, shift_d;
    logic [3:0]  gate_q, gate_d;        // tag[14:11]: slot 1..4 valid flags
    logic [6:0]  slot1_addr_q, slot1_addr_d;
    logic [9:0]  slot1_req_q, slot1_req_d;
    logic [19:0] slot3_q, slot3_d;

    // Output registers
    logic        codec_ready_q, codec_ready_d;
    logic [9:0]  slot_req_q, slot_req_d;
    logic [6:0]  status_addr_q, status_addr_d;
    logic [15:0] status_data_q, status_data_d;
    logic        status_valid_q, status_valid_d;
    logic [19:0] pcm_left_q, pcm_left_d;
    logic [19:0] pcm_right_q, pcm_right_d;
    logic        pcm_valid_q, pcm_valid_d;
    logic        frame_error_q, frame_error_d;

    // Combinational decode of the current cycle
    logic        sync_rise;
    logic        in_run;
    logic        resync;
    logic        missing_sync;
    logic        active;
    logic [7:0]  cur_bc;
    logic        sync_expect;
    logic        seen_eff;
    logic        sync_viol;
    logic [19:0] slot_word;

    // Classify this cycle: frame start, early resync, missing sync or plain bit
    always_comb begin
        sync_rise    = ac97_sync & ~sync_q;
        in_run       = (state_q == ST_RUN);
        // A rising edge in RUN while bc is not 0 means the previous frame was
        // cut short. bc reads 0 in RUN only after the 255->0 wrap.
        resync       = sync_rise & in_run & (bc_q != 8'd0);
        missing_sync = in_run & ~sync_rise & (bc_q == 8'd0);
        active       = sync_rise | (in_run & ~missing_sync);
        cur_bc       = sync_rise ? 8'd0 : bc_q;
        sync_expect  = (cur_bc < BC_SYNC_LEN);
        // The error-seen flag belongs to the previous frame on a start cycle.
        seen_eff     = sync_rise ? 1'b0 : err_seen_q;
        sync_viol    = active & (ac97_sync != sync_expect) & ~seen_eff;
        slot_word    = {shift_q, ac97_sdata_in};
    end

    // Next-state logic for framing, slot capture and outputs
    always_comb begin
        state_d        = state_q;
        bc_d           = bc_q;
        sync_d         = ac97_sync;
        err_seen_d     = err_seen_q;
        shift_d        = {shift_q[17:0], ac97_sdata_in};
        gate_d         = gate_q;
        slot1_addr_d   = slot1_addr_q;
        slot1_req_d    = slot1_req_q;
        slot3_d        = slot3_q;
        codec_ready_d  = codec_ready_q;
        slot_req_d     = slot_req_q;
        status_addr_d  = status_addr_q;
        status_data_d  = status_data_q;
        status_valid_d = 1'b0;
        pcm_left_d     = pcm_left_q;
        pcm_right_d    = pcm_right_q;
        pcm_valid_d    = 1'b0;
        frame_error_d  = resync | missing_sync | sync_viol;

        if (sync_rise) begin
            state_d = ST_RUN;
        end else if (missing_sync) begin
            state_d = ST_IDLE;
        end

        if (active) begin
            bc_d       = cur_bc + 8'd1;
            err_seen_d = seen_eff | sync_viol;
        end else begin
            bc_d       = 8'd0;
            err_seen_d = 1'b0;
        end

        if (missing_sync) begin
            codec_ready_d = 1'b0;
        end

        if (active) begin
            case (cur_bc)
                BC_TAG_END: begin
                    codec_ready_d = slot_word[15];
                    gate_d        = slot_word[14:11];
                end
                BC_SLOT1_END: begin
                    slot1_addr_d = slot_word[18:12];
                    slot1_req_d  = slot_word[11:2];
                end
                BC_SLOT2_END: begin
                    if (gate_q[3] && gate_q[2]) begin
                        status_addr_d  = slot1_addr_q;
                        slot_req_d     = slot1_req_q;
                        status_data_d  = slot_word[19:4];
                        status_valid_d = 1'b1;
                    end
                end
                BC_SLOT3_END: begin
                    slot3_d = slot_word;
                end
                BC_SLOT4_END: begin
                    if (gate_q[1] && gate_q[0]) begin
                        pcm_left_d  = slot3_q;
                        pcm_right_d = slot_word;
                        pcm_valid_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge ac97_bitclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            bc_q           <= 8'd0;
            sync_q         <= 1'b0;
            err_seen_q     <= 1'b0;
            shift_q        <= 19'd0;
            gate_q         <= 4'd0;
            slot1_addr_q   <= 7'd0;
            slot1_req_q    <= 10'd0;
            slot3_q        <= 20'd0;
            codec_ready_q  <= 1'b0;
            slot_req_q     <= 10'd0;
            status_addr_q  <= 7'd0;
            status_data_q  <= 16'd0;
            status_valid_q <= 1'b0;
            pcm_left_q     <= 20'd0;
            pcm_right_q    <= 20'd0;
            pcm_valid_q    <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bc_q           <= bc_d;
            sync_q         <= sync_d;
            err_seen_q     <= err_seen_d;
            shift_q        <= shift_d;
            gate_q         <= gate_d;
            slot1_addr_q   <= slot1_addr_d;
            slot1_req_q    <= slot1_req_d;
            slot3_q        <= slot3_d;
            codec_ready_q  <= codec_ready_d;
            slot_req_q     <= slot_req_d;
            status_addr_q  <= status_addr_d;
            status_data_q  <= status_data_d;
            status_valid_q <= status_valid_d;
            pcm_left_q     <= pcm_left_d;
            pcm_right_q    <= pcm_right_d;
            pcm_valid_q    <= pcm_valid_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign codec_ready  = codec_ready_q;
    assign slot_req     = slot_req_q;
    assign status_addr  = status_addr_q;
    assign status_data  = status_data_q;
    assign status_valid = status_valid_q;
    assign pcm_left     = pcm_left_q;
    assign pcm_right    = pcm_right_q;
    assign pcm_valid    = pcm_valid_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_ac97_frame_receiver.sv
// Testbench for ac97_frame_receiver.
// Frames are built as whole 256-bit words (tag, slots 1-4, random filler).
// Each frame also carries a sync length, an optional cut point and a gap.
// At build time the frame-level rules yield the expected pulses, tagged with
// the stream index of the sample that causes them. A monitor pops and
// compares them when the DUT shows them.
// Valid/pulse semantics: each *_valid / frame_error is a single-cycle pulse.
// There is no ready; the consumer must sample on the pulse.

module tb_ac97_frame_receiver;

    // ---------------- clock / reset ----------------
    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync    = 1'b0;
    logic        sdin    = 1'b0;

    logic        codec_ready;
    logic [9:0]  slot_req;
    logic [6:0]  status_addr;
    logic [15:0] status_data;
    logic        status_valid;
    logic [19:0] pcm_left;
    logic [19:0] pcm_right;
    logic        pcm_valid;
    logic        frame_error;

    always #5 clk = ~clk;

    ac97_frame_receiver dut (
        .ac97_bitclk   (clk),
        .reset_n       (reset_n),
        .ac97_sync     (sync),
        .ac97_sdata_in (sdin),
        .codec_ready   (codec_ready),
        .slot_req      (slot_req),
        .status_addr   (status_addr),
        .status_data   (status_data),
        .status_valid  (status_valid),
        .pcm_left      (pcm_left),
        .pcm_right     (pcm_right),
        .pcm_valid     (pcm_valid),
        .frame_error   (frame_error)
    );

    // ---------------- scoreboard state ----------------
    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    logic        stim_sync[$];
    logic        stim_data[$];
    // {idx[31:0], addr[6:0], req[9:0], data[15:0]}
    logic [64:0] exp_st_q[$];
    // {idx[31:0], left[19:0], right[19:0]}
    logic [71:0] exp_pcm_q[$];
    // {idx[31:0]}
    logic [31:0] exp_err_q[$];
    // {idx[31:0], value}
    logic [32:0] exp_cr_q[$];

    int          in_idx  = 0;
    bit          mon_en  = 1'b0;
    logic        cr_hold = 1'b0;
    // {status_addr, slot_req, status_data, pcm_left, pcm_right}
    logic [72:0] data_hold = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model / stimulus builder ----------------
    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            stim_sync.push_back(1'b0);
            stim_data.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    // cut: bits of this frame actually sent (256 = complete).
    // cut < 256 without cut_reset means the next frame starts right there.
    // gap > 0 after a complete frame means sync is missing afterwards.
    task automatic add_frame(input logic [15:0] tag, input logic [19:0] s1,
                             input logic [19:0] s2, input logic [19:0] s3,
                             input logic [19:0] s4, input int sync_len,
                             input int cut, input bit cut_reset, input int gap);
        int s;
        int v;
        logic [255:0] frame;
        s = stim_sync.size();
        frame = {tag, s1, s2, s3, s4, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < cut; b++) begin
            stim_sync.push_back(b < sync_len);
            stim_data.push_back(frame[255 - b]);
        end
        // First framing violation: sync must be high for exactly 16 bits.
        v = (sync_len < 16) ? sync_len : ((sync_len > 16) ? 16 : -1);
        if (v >= 0 && v < cut) exp_err_q.push_back(32'(s + v));
        if (cut > 15) exp_cr_q.push_back({32'(s + 15), tag[15]});
        if (cut > 55 && tag[14] && tag[13])
            exp_st_q.push_back({32'(s + 55), s1[18:12], s1[11:2], s2[19:4]});
        if (cut > 95 && tag[12] && tag[11])
            exp_pcm_q.push_back({32'(s + 95), s3, s4});
        if (cut < 256 && !cut_reset) exp_err_q.push_back(32'(s + cut));
        if (cut == 256 && gap > 0) begin
            exp_err_q.push_back(32'(s + 256));
            exp_cr_q.push_back({32'(s + 256), 1'b0});
            add_idle(gap);
        end
    endtask

    task automatic add_rand_frame(input bit last);
        int r;
        int sl;
        int cut;
        int gap;
        r  = $urandom_range(0, 9);
        sl = (r == 7) ? $urandom_range(1, 15) : ((r == 8) ? $urandom_range(17, 20) : 16);
        cut = 256;
        if (!last && $urandom_range(0, 5) == 0) cut = $urandom_range(25, 250);
        if (cut < 256) gap = 0;
        else if (last) gap = $urandom_range(1, 6);
        else gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
        add_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), sl, cut, 1'b0, gap);
    endtask

    // ---------------- driver ----------------
    task automatic run_stream(input bit end_in_reset);
        int n;
        n = stim_sync.size();
        in_idx = 0;
        mon_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sync   = stim_sync[i];
            sdin   = stim_data[i];
            in_idx = i;
        end
        @(posedge clk);
        #1;
        sync = 1'b0;
        sdin = 1'b0;
        if (end_in_reset) begin
            reset_n = 1'b0;
            mon_en  = 1'b0;
        end else begin
            in_idx = n;
            @(negedge clk);
            #1;
            mon_en = 1'b0;
        end
        chk("leftover_status", 32'(exp_st_q.size()), 0);
        chk("leftover_pcm", 32'(exp_pcm_q.size()), 0);
        chk("leftover_error", 32'(exp_err_q.size()), 0);
        stim_sync.delete();
        stim_data.delete();
        exp_cr_q.delete();
    endtask

    // ---------------- monitor ----------------
    task automatic monitor_step(input int idx);
        bit due;
        logic [64:0] st;
        logic [71:0] pc;
        logic [31:0] er;
        logic [32:0] cr;

        due = (exp_st_q.size() > 0) && (int'(exp_st_q[0][64:33]) == idx);
        chk("status_valid", status_valid, due);
        if (due) begin
            st = exp_st_q.pop_front();
            data_hold[72:40] = st[32:0];
        end

        due = (exp_pcm_q.size() > 0) && (int'(exp_pcm_q[0][71:40]) == idx);
        chk("pcm_valid", pcm_valid, due);
        if (due) begin
            pc = exp_pcm_q.pop_front();
            data_hold[39:0] = pc[39:0];
        end

        due = (exp_err_q.size() > 0) && (int'(exp_err_q[0]) == idx);
        chk("frame_error", frame_error, due);
        if (due) er = exp_err_q.pop_front();

        if (exp_cr_q.size() > 0 && int'(exp_cr_q[0][32:1]) == idx) begin
            cr = exp_cr_q.pop_front();
            cr_hold = cr[0];
        end
        chk("codec_ready", codec_ready, cr_hold);
        chk("data_outputs", {status_addr, slot_req, status_data, pcm_left, pcm_right}, data_hold);
    endtask

    always @(negedge clk) begin
        if (mon_en && in_idx >= 1) monitor_step(in_idx - 1);
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pulses"}, {status_valid, pcm_valid, frame_error}, 3'b000);
        chk({tag, "_codec_ready"}, codec_ready, 1'b0);
        chk({tag, "_data"}, {status_addr, slot_req, status_data, pcm_left, pcm_right}, 73'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        cr_hold   = 1'b0;
        data_hold = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed: nominal, tag gating, early sync, missing sync, short sync
        add_idle(3);
        add_frame(16'hF800, {1'b0, 7'h26, 10'h000, 2'b00}, {16'h000F, 4'h0},
                  20'hABCDE, 20'h12345, 16, 256, 1'b0, 0);
        add_frame(16'h8000, 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), 16, 256, 1'b0, 0);
        add_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), 16, 100, 1'b0, 0);
        add_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), 16, 256, 1'b0, 5);
        add_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), 10, 256, 1'b0, 0);
        add_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), 16, 256, 1'b0, 3);
        run_stream(1'b0);

        // Randomised frames
        add_idle(2);
        for (int f = 0; f < 10; f++) add_rand_frame(f == 9);
        run_stream(1'b0);

        // Reset in the middle of a frame, at bit 60
        add_idle(2);
        add_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), 16, 60, 1'b1, 0);
        run_stream(1'b1);
        repeat (2) @(negedge clk);
        check_reset_outputs("midframe_reset");
        cr_hold   = 1'b0;
        data_hold = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Recovery after reset
        add_idle(2);
        add_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom),
                  20'($urandom), 16, 256, 1'b0, 4);
        run_stream(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
